// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - request, FPU operand/result and response signals of the shared-FPU arbiter
interface fpu_arbiter_if;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        fpu_valid, fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output fpu_valid, fpu_op, fpu_a, fpu_b,
    input  fpu_result,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  rsp0_ready, rsp1_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  fpu_valid, fpu_op, fpu_a, fpu_b,
    output fpu_result,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output rsp0_ready, rsp1_ready,
    input  busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one fixed-latency FPU between two requesters
// Credit (FIFO occupancy + in-flight) guarantees every returning result has a free FIFO slot.
module fpu_arbiter #(
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  fpu_arbiter_if.slave bus
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

  logic [1:0]    req_valid, req_op, rsp_ready;
  logic [31:0]   req_a [2];
  logic [31:0]   req_b [2];
  logic [1:0]    credit, elig, grant, push, pop;
  logic          rr_q, rr_d;
  logic          fpu_valid_q, fpu_op_q, fpu_owner_q;
  logic [31:0]   fpu_a_q, fpu_b_q;
  logic [LATENCY-1:0] sr_valid_q, sr_owner_q;
  logic [CW-1:0] occ_q [2];
  logic [CW-1:0] occ_d [2];
  logic [CW-1:0] inflight_q [2];
  logic [CW-1:0] inflight_d [2];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [31:0]   mem_q [2][RSP_DEPTH];

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_op    = {bus.req1_op, bus.req0_op};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;

  always_comb begin
    credit     = '0;
    push       = '0;
    pop        = '0;
    grant      = '0;
    rr_d       = rr_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    for (int n = 0; n < 2; n++) begin
      credit[n] = ({1'b0, occ_q[n]} + {1'b0, inflight_q[n]}) < DEPTH_C;
      push[n]   = sr_valid_q[LATENCY-1] && (sr_owner_q[LATENCY-1] == 1'(n));
      pop[n]    = (occ_q[n] != '0) && rsp_ready[n];
    end
    elig = req_valid & credit & {2{reset}};
    // rr_q names the port that wins the next contention
    if (elig[0] && (!elig[1] || !rr_q)) grant[0] = 1'b1;
    else if (elig[1])                    grant[1] = 1'b1;
    if (grant[0])      rr_d = 1'b1;
    else if (grant[1]) rr_d = 1'b0;
    for (int n = 0; n < 2; n++) begin
      inflight_d[n] = inflight_q[n] + CW'(grant[n]) - CW'(push[n]);
      occ_d[n]      = occ_q[n] + CW'(push[n]) - CW'(pop[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q        <= 1'b0;
      fpu_valid_q <= 1'b0;
      fpu_op_q    <= 1'b0;
      fpu_owner_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      sr_valid_q  <= '0;
      sr_owner_q  <= '0;
      for (int n = 0; n < 2; n++) begin
        occ_q[n]      <= '0;
        inflight_q[n] <= '0;
        wr_ptr_q[n]   <= '0;
        rd_ptr_q[n]   <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      fpu_valid_q <= |grant;
      if (|grant) begin
        fpu_op_q    <= req_op[grant[1]];
        fpu_a_q     <= req_a[grant[1]];
        fpu_b_q     <= req_b[grant[1]];
        fpu_owner_q <= grant[1];
      end
      sr_valid_q[0] <= fpu_valid_q;
      sr_owner_q[0] <= fpu_owner_q;
      for (int i = 1; i < LATENCY; i++) begin
        sr_valid_q[i] <= sr_valid_q[i-1];
        sr_owner_q[i] <= sr_owner_q[i-1];
      end
      for (int n = 0; n < 2; n++) begin
        occ_q[n]      <= occ_d[n];
        inflight_q[n] <= inflight_d[n];
        if (push[n]) wr_ptr_q[n] <= wr_ptr_q[n] + 1'b1;
        if (pop[n])  rd_ptr_q[n] <= rd_ptr_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset && push[n]) mem_q[n][wr_ptr_q[n]] <= bus.fpu_result;
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.fpu_valid   = fpu_valid_q;
  assign bus.fpu_op      = fpu_op_q;
  assign bus.fpu_a       = fpu_a_q;
  assign bus.fpu_b       = fpu_b_q;
  assign bus.rsp0_valid  = occ_q[0] != '0;
  assign bus.rsp1_valid  = occ_q[1] != '0;
  assign bus.rsp0_result = mem_q[0][rd_ptr_q[0]];
  assign bus.rsp1_result = mem_q[1][rd_ptr_q[1]];
  assign bus.busy        = (occ_q[0] | occ_q[1] | inflight_q[0] | inflight_q[1]) != '0;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - randomized and directed bench for fpu_arbiter against a queue-based reference
module tb_fpu_arbiter;
  localparam int LAT   = 2;
  localparam int DEP   = 4;
  localparam int DEP_B = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_arbiter_if bus_a ();
  fpu_arbiter_if bus_b ();

  fpu_arbiter #(.LATENCY(LAT), .RSP_DEPTH(DEP))   dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fpu_arbiter #(.LATENCY(1),   .RSP_DEPTH(DEP_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in FPU: known vectors give real IEEE results, anything else a deterministic mix.
  function automatic logic [31:0] fpu_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op && a == 32'h40000000 && b == 32'h40400000)  return 32'h40C00000;
    if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return op ? ((a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9) : (a + b + 32'h00001234);
  endfunction

  logic [31:0] pipe_a [LAT];
  logic [31:0] pipe_b;
  always @(posedge clk) begin
    pipe_a[0] <= bus_a.fpu_valid ? fpu_fn(bus_a.fpu_op, bus_a.fpu_a, bus_a.fpu_b) : 32'h0;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= bus_b.fpu_valid ? fpu_fn(bus_b.fpu_op, bus_b.fpu_a, bus_b.fpu_b) : 32'h0;
  end
  assign bus_a.fpu_result = pipe_a[LAT-1];
  assign bus_b.fpu_result = pipe_b;

  typedef struct packed {
    logic [31:0] res;
    int          rdy;
  } exp_t;

  exp_t        q [2][$];
  int          outst [2];
  int          acc_cnt [2];
  logic [31:0] last_pop [2];
  bit          pref;
  bit          prev_acc;
  logic        prev_op;
  logic [31:0] prev_a, prev_b;
  int          cyc = 0;

  task automatic step_a();
    logic [1:0]  v, rr, g, e, rdy_got, rv_got, rv_exp, pop;
    logic [31:0] res_got [2];
    logic        op_in [2];
    logic [31:0] a_in [2];
    logic [31:0] b_in [2];
    exp_t        item;
    #1;
    v       = {bus_a.req1_valid, bus_a.req0_valid};
    rr      = {bus_a.rsp1_ready, bus_a.rsp0_ready};
    rdy_got = {bus_a.req1_ready, bus_a.req0_ready};
    rv_got  = {bus_a.rsp1_valid, bus_a.rsp0_valid};
    res_got[0] = bus_a.rsp0_result;  res_got[1] = bus_a.rsp1_result;
    op_in[0]   = bus_a.req0_op;      op_in[1]   = bus_a.req1_op;
    a_in[0]    = bus_a.req0_a;       a_in[1]    = bus_a.req1_a;
    b_in[0]    = bus_a.req0_b;       b_in[1]    = bus_a.req1_b;
    for (int n = 0; n < 2; n++) e[n] = v[n] && (outst[n] < DEP);
    g[0] = e[0] && (!e[1] || !pref);
    g[1] = e[1] && !g[0];
    for (int n = 0; n < 2; n++) check_eq($sformatf("req%0d_ready@%0d", n, cyc), rdy_got[n], g[n]);
    check_eq($sformatf("fpu_valid@%0d", cyc), bus_a.fpu_valid, prev_acc);
    if (prev_acc) begin
      check_eq("fpu_op", bus_a.fpu_op, prev_op);
      check_eq("fpu_a", bus_a.fpu_a, prev_a);
      check_eq("fpu_b", bus_a.fpu_b, prev_b);
    end
    check_eq($sformatf("busy@%0d", cyc), bus_a.busy, (outst[0] + outst[1]) != 0);
    for (int n = 0; n < 2; n++) begin
      rv_exp[n] = (q[n].size() > 0) && (q[n][0].rdy <= cyc);
      check_eq($sformatf("rsp%0d_valid@%0d", n, cyc), rv_got[n], rv_exp[n]);
      if (rv_exp[n]) check_eq($sformatf("rsp%0d_result@%0d", n, cyc), res_got[n], q[n][0].res);
      pop[n] = rv_exp[n] && rr[n];
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (pop[n]) begin
        last_pop[n] = res_got[n];
        void'(q[n].pop_front());
        outst[n]--;
      end
    end
    prev_acc = |g;
    for (int n = 0; n < 2; n++) begin
      if (g[n]) begin
        item.res = fpu_fn(op_in[n], a_in[n], b_in[n]);
        item.rdy = cyc + 2 + LAT;
        q[n].push_back(item);
        outst[n]++;
        acc_cnt[n]++;
        pref    = (n == 0);
        prev_op = op_in[n];
        prev_a  = a_in[n];
        prev_b  = b_in[n];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_a(input int cycles);
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    bus_a.rsp0_ready = 1'b1;
    bus_a.rsp1_ready = 1'b1;
    repeat (cycles) step_a();
  endtask

  task automatic do_reset_a();
    reset = 1'b0;
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    #1;
    check_eq("rst_req0_ready", bus_a.req0_ready, 1'b0);
    check_eq("rst_req1_ready", bus_a.req1_ready, 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst_fpu_valid", bus_a.fpu_valid, 1'b0);
    check_eq("rst_fpu_op", bus_a.fpu_op, 1'b0);
    check_eq("rst_fpu_a", bus_a.fpu_a, 32'h0);
    check_eq("rst_fpu_b", bus_a.fpu_b, 32'h0);
    check_eq("rst_busy", bus_a.busy, 1'b0);
    check_eq("rst_rsp0_valid", bus_a.rsp0_valid, 1'b0);
    check_eq("rst_rsp1_valid", bus_a.rsp1_valid, 1'b0);
    for (int n = 0; n < 2; n++) begin
      q[n].delete();
      outst[n] = 0;
    end
    pref     = 1'b0;
    prev_acc = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
  endtask

  task automatic run_b();
    logic [31:0] qb [$];
    int got  = 0;
    int outb = 0;
    bus_b.req0_valid = 1'b1;
    for (int k = 0; k < 300 && got < 12; k++) begin
      bus_b.req0_op    = 1'($urandom_range(0, 1));
      bus_b.req0_a     = $urandom;
      bus_b.req0_b     = $urandom;
      bus_b.rsp0_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_eq($sformatf("b_ready@%0d", k), bus_b.req0_ready, outb < DEP_B);
      if (bus_b.rsp0_valid && bus_b.rsp0_ready) begin
        if (qb.size() == 0) check_eq("b_rsp_unexpected", bus_b.rsp0_valid, 1'b0);
        else begin
          check_eq($sformatf("b_result%0d", got), bus_b.rsp0_result, qb.pop_front());
          got++;
          outb--;
        end
      end
      if (bus_b.req0_ready) begin
        qb.push_back(fpu_fn(bus_b.req0_op, bus_b.req0_a, bus_b.req0_b));
        outb++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("b_count", got, 12);
    bus_b.req0_valid = 1'b0;
  endtask

  initial begin
    int start;
    reset = 1'b0;
    bus_a.req0_valid = 0; bus_a.req0_op = 0; bus_a.req0_a = 0; bus_a.req0_b = 0;
    bus_a.req1_valid = 0; bus_a.req1_op = 0; bus_a.req1_a = 0; bus_a.req1_b = 0;
    bus_a.rsp0_ready = 1; bus_a.rsp1_ready = 1;
    bus_b.req0_valid = 0; bus_b.req0_op = 0; bus_b.req0_a = 0; bus_b.req0_b = 0;
    bus_b.req1_valid = 0; bus_b.req1_op = 0; bus_b.req1_a = 0; bus_b.req1_b = 0;
    bus_b.rsp0_ready = 1; bus_b.rsp1_ready = 1;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    last_pop[0] = 0; last_pop[1] = 0;
    @(negedge clk);
    do_reset_a();

    bus_a.req0_valid = 1; bus_a.req0_op = 0;
    bus_a.req0_a = 32'h3F800000; bus_a.req0_b = 32'h40000000;
    step_a();
    idle_a(8);
    check_eq("single_add_result", last_pop[0], 32'h40400000);

    bus_a.req0_op = 1; bus_a.req0_a = 32'h40000000; bus_a.req0_b = 32'h40400000;
    bus_a.req1_op = 0; bus_a.req1_a = 32'h3F800000; bus_a.req1_b = 32'h3F800000;
    bus_a.req0_valid = 1; bus_a.req1_valid = 1;
    repeat (12) step_a();
    idle_a(10);
    check_eq("contend_rsp0", last_pop[0], 32'h40C00000);
    check_eq("contend_rsp1", last_pop[1], 32'h40000000);

    start = acc_cnt[0];
    bus_a.rsp0_ready = 0; bus_a.req0_valid = 1; bus_a.req1_valid = 1;
    repeat (14) step_a();
    check_eq("bp_accepts", acc_cnt[0] - start, DEP);
    bus_a.rsp0_ready = 1;
    repeat (8) step_a();
    idle_a(10);

    start = acc_cnt[0];
    bus_a.req0_valid = 1;
    for (int k = 0; k < 200 && (acc_cnt[0] - start) < 10; k++) begin
      bus_a.rsp0_ready = (k % 2 == 0);
      bus_a.req0_op = 1'($urandom_range(0, 1));
      bus_a.req0_a  = $urandom;
      bus_a.req0_b  = $urandom;
      step_a();
    end
    check_eq("wrap_accepts", acc_cnt[0] - start, 10);
    bus_a.req0_valid = 0;
    for (int k = 0; k < 40; k++) begin
      bus_a.rsp0_ready = (k % 2 == 0);
      step_a();
    end
    check_eq("wrap_drain", q[0].size(), 0);

    repeat (400) begin
      bus_a.req0_valid = ($urandom_range(0, 9) < 7);
      bus_a.req1_valid = ($urandom_range(0, 9) < 7);
      bus_a.req0_op = 1'($urandom_range(0, 1));
      bus_a.req1_op = 1'($urandom_range(0, 1));
      bus_a.req0_a = $urandom; bus_a.req0_b = $urandom;
      bus_a.req1_a = $urandom; bus_a.req1_b = $urandom;
      bus_a.rsp0_ready = ($urandom_range(0, 9) < 6);
      bus_a.rsp1_ready = ($urandom_range(0, 9) < 6);
      step_a();
    end
    idle_a(20);
    check_eq("rand_drain0", q[0].size(), 0);
    check_eq("rand_drain1", q[1].size(), 0);

    bus_a.req0_valid = 1;
    repeat (3) step_a();
    bus_a.req0_valid = 0;
    step_a();
    do_reset_a();
    idle_a(8);
    bus_a.req0_valid = 1; bus_a.req1_valid = 1;
    step_a();
    idle_a(10);

    run_b();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
